busca_instrucao: RTL and testbench

//  Fetch stage feeding MemInst: owns the program counter and drives its word address.

---
 rtl/fpgmips_pkg.sv | 21 ++
 rtl/contador_programa.sv | 35 +++
 rtl/busca_instrucao.sv | 100 ++++++++++
 tb/tb_busca_instrucao.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fpgmips_pkg.sv
// fpgmips shared definitions: opcode field bounds, HLT opcode
// and the fetch-stage state encoding.
package fpgmips_pkg;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;

  localparam logic [OP_MSB-OP_LSB:0] OP_HLT = 5'b00001;

  typedef enum logic {
    EXECUTANDO = 1'b0,
    PARADO     = 1'b1
  } estado_busca_t;

  function automatic logic eh_hlt(
    input logic [31:0] inst
  );
    return inst[OP_MSB:OP_LSB] == OP_HLT;
  endfunction

endpackage

// File: rtl/contador_programa.sv
// Program counter register and next-PC mux.
// Ports: clock, reset, desvio/alvo (redirect), avancar (pc+1), pc.
module contador_programa
  import fpgmips_pkg::*;
#(
  parameter int LARG_PC    = 5,
  parameter int PC_INICIAL = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               desvio,
  input  logic               avancar,
  input  logic [LARG_PC-1:0] alvo,
  output logic [LARG_PC-1:0] pc
);

  logic [LARG_PC-1:0] pc_prox;

  // Increment wraps naturally at LARG_PC bits.
  always_comb begin
    pc_prox = pc;
    if (desvio)
      pc_prox = alvo;
    else if (avancar)
      pc_prox = pc + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      pc <= LARG_PC'(PC_INICIAL);
    else
      pc <= pc_prox;
  end

endmodule

// File: rtl/busca_instrucao.sv
// Fetch stage: drives MemInst address, fills IF/ID, handles
// stall, redirect and HLT. Optional ciclos output: CONTADOR_CICLOS_EN.
// Ports: clock, reset, endereco, instrucao_mem, parar, desvio,
// alvo_desvio, instrucao, pc_instrucao, valida, halt [, ciclos].
module busca_instrucao
  import fpgmips_pkg::*;
#(
  parameter int LARG_PC    = 5,
  parameter int PC_INICIAL = 0
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] endereco,
  input  logic [31:0] instrucao_mem,
  input  logic        parar,
  input  logic        desvio,
  input  logic [31:0] alvo_desvio,
  output logic [31:0] instrucao,
  output logic [31:0] pc_instrucao,
  output logic        valida,
`ifdef CONTADOR_CICLOS_EN
  output logic [31:0] ciclos,
`endif
  output logic        halt
);

  estado_busca_t      estado;
  estado_busca_t      estado_prox;
  logic [LARG_PC-1:0] pc;
  logic               hlt_mem;
  logic               avancar;
  logic               unused_alvo;

  assign unused_alvo = ^alvo_desvio[31:LARG_PC];

  assign endereco = {{(32-LARG_PC){1'b0}}, pc};
  assign hlt_mem  = eh_hlt(instrucao_mem);

  assign avancar = !desvio && !parar &&
                   (estado == EXECUTANDO) && !hlt_mem;

  contador_programa #(
    .LARG_PC   (LARG_PC),
    .PC_INICIAL(PC_INICIAL)
  ) u_pc (
    .clock  (clock),
    .reset  (reset),
    .desvio (desvio),
    .avancar(avancar),
    .alvo   (alvo_desvio[LARG_PC-1:0]),
    .pc     (pc)
  );

  always_comb begin
    estado_prox = estado;
    if (desvio)
      estado_prox = EXECUTANDO;
    else if (!parar && estado == EXECUTANDO && hlt_mem)
      estado_prox = PARADO;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      estado <= EXECUTANDO;
    else
      estado <= estado_prox;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instrucao    <= '0;
      pc_instrucao <= '0;
      valida       <= 1'b0;
      halt         <= 1'b0;
    end else if (desvio) begin
      valida <= 1'b0;
      halt   <= 1'b0;
    end else if (!parar) begin
      if (estado == EXECUTANDO) begin
        instrucao    <= instrucao_mem;
        pc_instrucao <= endereco;
        valida       <= 1'b1;
        if (hlt_mem)
          halt <= 1'b1;
      end else begin
        valida <= 1'b0;
      end
    end
  end

`ifdef CONTADOR_CICLOS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      ciclos <= '0;
    else if (estado == EXECUTANDO && ciclos != '1)
      ciclos <= ciclos + 1'b1;
  end
`endif

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed bench for busca_instrucao: sequential fetch, HLT,
// stall, redirect, wrap and async reset.
module tb_busca_instrucao;

  logic        clock;
  logic        reset;
  logic [31:0] endereco;
  logic [31:0] instrucao_mem;
  logic        parar;
  logic        desvio;
  logic [31:0] alvo_desvio;
  logic [31:0] instrucao;
  logic [31:0] pc_instrucao;
  logic        valida;
  logic        halt;
`ifdef CONTADOR_CICLOS_EN
  logic [31:0] ciclos;
`endif

  logic [31:0] mem [32];
  int total;
  int bad;

  localparam logic [31:0] HLT = 32'h0800_0000;

  busca_instrucao #(
    .LARG_PC   (5),
    .PC_INICIAL(0)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .endereco     (endereco),
    .instrucao_mem(instrucao_mem),
    .parar        (parar),
    .desvio       (desvio),
    .alvo_desvio  (alvo_desvio),
    .instrucao    (instrucao),
    .pc_instrucao (pc_instrucao),
    .valida       (valida),
`ifdef CONTADOR_CICLOS_EN
    .ciclos       (ciclos),
`endif
    .halt         (halt)
  );

  always_comb instrucao_mem = mem[endereco[4:0]];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic verifica(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 32; i++)
      mem[i] = 32'h1000_0000 | 32'(i * 3 + 7);
    mem[3] = HLT;

    reset       = 1'b1;
    parar       = 1'b0;
    desvio      = 1'b0;
    alvo_desvio = '0;

    // reset state
    #2;
    verifica("rst_end", endereco, 0);
    verifica("rst_val", 32'(valida), 0);
    verifica("rst_hlt", 32'(halt), 0);
    verifica("rst_ins", instrucao, 0);
    verifica("rst_pci", pc_instrucao, 0);
    tick;
    reset = 1'b0;

    // sequential fetch 0..2
    for (int k = 0; k < 3; k++) begin
      verifica("seq_end", endereco, 32'(k));
      tick;
      verifica("seq_ins", instrucao, mem[k]);
      verifica("seq_pci", pc_instrucao, 32'(k));
      verifica("seq_val", 32'(valida), 1);
    end

    // halt at address 3
    verifica("h_end0", endereco, 3);
    tick;
    verifica("h_hlt", 32'(halt), 1);
    verifica("h_ins", instrucao, HLT);
    verifica("h_val", 32'(valida), 1);
    verifica("h_end", endereco, 3);
`ifdef CONTADOR_CICLOS_EN
    verifica("h_cic", ciclos, 4);
`endif
    tick;
    verifica("h_val2", 32'(valida), 0);
    verifica("h_end2", endereco, 3);
    tick;
    verifica("h_val3", 32'(valida), 0);
    verifica("h_hlt3", 32'(halt), 1);
    verifica("h_ins3", instrucao, HLT);
`ifdef CONTADOR_CICLOS_EN
    verifica("h_cic3", ciclos, 4);
`endif

    // redirect out of PARADO to 0
    mem[3]      = 32'h1000_0100;
    desvio      = 1'b1;
    alvo_desvio = 0;
    tick;
    desvio = 1'b0;
    verifica("r0_hlt", 32'(halt), 0);
    verifica("r0_end", endereco, 0);
    verifica("r0_val", 32'(valida), 0);
    tick;
    verifica("r0_ins", instrucao, mem[0]);
    verifica("r0_val1", 32'(valida), 1);
    verifica("r0_end1", endereco, 1);
    tick;
    verifica("r0_end2", endereco, 2);

    // stall two cycles at pc=2
    parar = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick;
      verifica("st_end", endereco, 2);
      verifica("st_ins", instrucao, mem[1]);
      verifica("st_pci", pc_instrucao, 1);
      verifica("st_val", 32'(valida), 1);
    end
    parar = 1'b0;
    tick;
    verifica("st_rel_e", endereco, 3);
    verifica("st_rel_i", instrucao, mem[2]);
    verifica("st_rel_p", pc_instrucao, 2);
    tick;
    verifica("st_nx_i", instrucao, mem[3]);
    tick;
    verifica("rd_pc5", endereco, 5);

    // redirect to 10 with concurrent stall
    desvio      = 1'b1;
    parar       = 1'b1;
    alvo_desvio = 10;
    tick;
    desvio = 1'b0;
    parar  = 1'b0;
    verifica("rd_end", endereco, 10);
    verifica("rd_val", 32'(valida), 0);
    tick;
    verifica("rd_ins", instrucao, mem[10]);
    verifica("rd_pci", pc_instrucao, 10);
    verifica("rd_val1", 32'(valida), 1);
    verifica("rd_end1", endereco, 11);

    // wrap: target upper bits ignored, 31 -> 0
    desvio      = 1'b1;
    alvo_desvio = 32'hFFFF_FFFF;
    tick;
    desvio = 1'b0;
    verifica("wr_end", endereco, 31);
    tick;
    verifica("wr_ins", instrucao, mem[31]);
    verifica("wr_pci", pc_instrucao, 31);
    verifica("wr_end0", endereco, 0);

    // async reset mid-cycle at pc=7
    desvio      = 1'b1;
    alvo_desvio = 6;
    tick;
    desvio = 1'b0;
    tick;
    verifica("ar_pre_e", endereco, 7);
    verifica("ar_pre_v", 32'(valida), 1);
    #2;
    reset = 1'b1;
    #1;
    verifica("ar_end", endereco, 0);
    verifica("ar_val", 32'(valida), 0);
    verifica("ar_ins", instrucao, 0);
    verifica("ar_pci", pc_instrucao, 0);
    verifica("ar_hlt", 32'(halt), 0);
`ifdef CONTADOR_CICLOS_EN
    verifica("ar_cic", ciclos, 0);
`endif
    #1;
    reset = 1'b0;
    #1;
    verifica("ar_rel_e", endereco, 0);
    tick;
    verifica("ar_ins1", instrucao, mem[0]);
    verifica("ar_end1", endereco, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
